// File: rtl/pwm_sequencer.sv
// ============================================================================
// pwm_sequencer : plays a duty table into a PWM compare register at wraps
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_sequencer #(
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned WIDTH           = 16,
  parameter logic [15:0] COMPARE_ADDRESS = 16'h0008
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     table_we,
  input  logic [$clog2(DEPTH)-1:0] table_addr,
  input  logic [WIDTH-1:0]         table_data,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic [$clog2(DEPTH):0]   length,
  input  logic [7:0]               repeat_count,
  input  logic                     period_wrap,
  output logic                     peripheralBus_we,
  output logic [15:0]              peripheralBus_address,
  output logic [3:0]               peripheralBus_byteSelect,
  output logic [31:0]              peripheralBus_dataWrite,
  input  logic                     peripheralBus_busy,
  output logic                     running,
  output logic [$clog2(DEPTH)-1:0] step_index,
  output logic                     seq_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  logic [WIDTH-1:0] table_q [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] index_q, index_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [7:0]    rep_q, rep_d;
  logic          stop_pend_q, stop_pend_d;
  logic          wrap_pend_q, wrap_pend_d;
  logic          we_q, we_d;
  logic [15:0]   addr_q, addr_d;
  logic [3:0]    bs_q, bs_d;
  logic [31:0]   data_q, data_d;
  logic          running_q, running_d;
  logic [AW-1:0] step_q, step_d;
  logic          done_q, done_d;

  logic [LW-1:0] len_eff;
  logic [7:0]    rep_eff;
  logic          issue;
  logic [AW-1:0] fetch_idx;

  assign len_eff = (length > LW'(DEPTH)) ? LW'(DEPTH) : length;
  assign rep_eff = (repeat_count == 8'd0) ? 8'd1 : repeat_count;

  // Table has no reset so its contents survive a sequencer reset.
  always_ff @(posedge clk) begin
    if (table_we) begin
      table_q[table_addr] <= table_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    rep_d       = rep_q;
    stop_pend_d = stop_pend_q;
    wrap_pend_d = wrap_pend_q;
    we_d        = we_q;
    addr_d      = addr_q;
    bs_d        = bs_q;
    data_d      = data_q;
    running_d   = running_q;
    step_d      = step_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    fetch_idx   = index_q;

    case (state_q)
      IDLE: begin
        if (start && !stop && (len_eff != '0)) begin
          state_d     = WRITE;
          index_d     = '0;
          cnt_d       = 8'd0;
          len_d       = len_eff;
          rep_d       = rep_eff;
          stop_pend_d = 1'b0;
          wrap_pend_d = 1'b0;
          issue       = 1'b1;
          fetch_idx   = '0;
        end
      end

      WRITE: begin
        if (stop)        stop_pend_d = 1'b1;
        if (period_wrap) wrap_pend_d = 1'b1;
        if (!peripheralBus_busy) begin
          step_d = index_q;
          we_d   = 1'b0;
          addr_d = 16'd0;
          bs_d   = 4'd0;
          data_d = 32'd0;
          if (stop_pend_q || stop) begin
            state_d     = IDLE;
            running_d   = 1'b0;
            stop_pend_d = 1'b0;
            wrap_pend_d = 1'b0;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (stop) begin
          state_d     = IDLE;
          running_d   = 1'b0;
          wrap_pend_d = 1'b0;
        end else if (wrap_pend_q || period_wrap) begin
          // A wrap latched during the write counts as this cycle's wrap.
          wrap_pend_d = 1'b0;
          if ((cnt_q + 8'd1) == rep_q) begin
            cnt_d = 8'd0;
            if ((LW'(index_q) + LW'(1)) < len_q) begin
              index_d   = index_q + AW'(1);
              state_d   = WRITE;
              issue     = 1'b1;
              fetch_idx = index_q + AW'(1);
            end else if (loop) begin
              index_d   = '0;
              state_d   = WRITE;
              issue     = 1'b1;
              fetch_idx = '0;
            end else begin
              state_d   = IDLE;
              running_d = 1'b0;
              done_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        running_d = 1'b0;
      end
    endcase

    // Duty is captured at issue so the bus stays stable across a stall.
    if (issue) begin
      we_d      = 1'b1;
      addr_d    = COMPARE_ADDRESS;
      bs_d      = 4'hF;
      data_d    = 32'(table_q[fetch_idx]);
      running_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      index_q     <= '0;
      cnt_q       <= 8'd0;
      len_q       <= '0;
      rep_q       <= 8'd0;
      stop_pend_q <= 1'b0;
      wrap_pend_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 16'd0;
      bs_q        <= 4'd0;
      data_q      <= 32'd0;
      running_q   <= 1'b0;
      step_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      rep_q       <= rep_d;
      stop_pend_q <= stop_pend_d;
      wrap_pend_q <= wrap_pend_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      bs_q        <= bs_d;
      data_q      <= data_d;
      running_q   <= running_d;
      step_q      <= step_d;
      done_q      <= done_d;
    end
  end

  assign peripheralBus_we         = we_q;
  assign peripheralBus_address    = addr_q;
  assign peripheralBus_byteSelect = bs_q;
  assign peripheralBus_dataWrite  = data_q;
  assign running                  = running_q;
  assign step_index               = step_q;
  assign seq_done                 = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_sequencer.sv
// ============================================================================
// tb_pwm_sequencer : directed vector bench for pwm_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pwm_sequencer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        table_we;
  logic [3:0]  table_addr;
  logic [15:0] table_data;
  logic        start, stop, loop;
  logic [4:0]  length;
  logic [7:0]  repeat_count;
  logic        period_wrap;
  logic        we;
  logic [15:0] addr;
  logic [3:0]  bs;
  logic [31:0] data;
  logic        busy;
  logic        running;
  logic [3:0]  step_index;
  logic        seq_done;

  pwm_sequencer #(
    .DEPTH(DEPTH),
    .WIDTH(16),
    .COMPARE_ADDRESS(16'h0008)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .table_we                (table_we),
    .table_addr              (table_addr),
    .table_data              (table_data),
    .start                   (start),
    .stop                    (stop),
    .loop                    (loop),
    .length                  (length),
    .repeat_count            (repeat_count),
    .period_wrap             (period_wrap),
    .peripheralBus_we        (we),
    .peripheralBus_address   (addr),
    .peripheralBus_byteSelect(bs),
    .peripheralBus_dataWrite (data),
    .peripheralBus_busy      (busy),
    .running                 (running),
    .step_index              (step_index),
    .seq_done                (seq_done)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] wr_data [$];
  int          done_cnt = 0;
  int          bad_bus  = 0;

  // Records every accepted bus write and every seq_done cycle.
  always @(posedge clk) begin
    if (rst && we && !busy) begin
      wr_data.push_back(data);
      if (addr !== 16'h0008 || bs !== 4'hF) bad_bus++;
    end
    if (seq_done === 1'b1) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_log;
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_wrap;
    repeat (7) tick();
    period_wrap = 1'b1;
    tick();
    period_wrap = 1'b0;
  endtask

  task automatic do_stop;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  typedef struct {
    int len;
    int rep;
    bit lp;
    int nwraps;
    int exp_writes;
    int exp_last;
    int exp_done;
    bit exp_run;
    int exp_step;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{len:4,  rep:1, lp:0, nwraps:4,  exp_writes:4,  exp_last:40,  exp_done:1, exp_run:0, exp_step:3};
    vecs[1] = '{len:2,  rep:3, lp:1, nwraps:6,  exp_writes:3,  exp_last:10,  exp_done:0, exp_run:1, exp_step:0};
    vecs[2] = '{len:0,  rep:1, lp:0, nwraps:2,  exp_writes:0,  exp_last:0,   exp_done:0, exp_run:0, exp_step:-1};
    vecs[3] = '{len:20, rep:1, lp:0, nwraps:16, exp_writes:16, exp_last:160, exp_done:1, exp_run:0, exp_step:15};
    vecs[4] = '{len:1,  rep:0, lp:0, nwraps:1,  exp_writes:1,  exp_last:10,  exp_done:1, exp_run:0, exp_step:0};
    vecs[5] = '{len:3,  rep:2, lp:0, nwraps:5,  exp_writes:3,  exp_last:30,  exp_done:0, exp_run:1, exp_step:2};

    rst = 1'b0; table_we = 1'b0; table_addr = '0; table_data = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; length = '0; repeat_count = '0;
    period_wrap = 1'b0; busy = 1'b0;

    repeat (3) tick();
    chk("reset_we", {31'd0, we}, 32'd0);
    chk("reset_bus", {addr, 12'd0, bs}, 32'd0);
    chk("reset_data", data, 32'd0);
    chk("reset_run_step_done", {26'd0, running, step_index, seq_done}, 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      table_we = 1'b1; table_addr = 4'(i); table_data = 16'((i + 1) * 10);
      tick();
    end
    table_we = 1'b0;

    // Start/wrap latency on a plain run.
    length = 5'd4; repeat_count = 8'd1; loop = 1'b0;
    clear_log();
    pulse_start();
    chk("start_we", {31'd0, we}, 32'd1);
    chk("start_data", data, 32'd10);
    chk("start_addr_bs", {addr, 12'd0, bs}, {16'h0008, 12'd0, 4'hF});
    chk("start_running", {31'd0, running}, 32'd1);
    tick();
    chk("complete_we", {31'd0, we}, 32'd0);
    chk("complete_step", {28'd0, step_index}, 32'd0);
    tick();
    period_wrap = 1'b1;
    tick();
    period_wrap = 1'b0;
    chk("wrap_we", {31'd0, we}, 32'd1);
    chk("wrap_data", data, 32'd20);
    tick();
    chk("wrap_step", {28'd0, step_index}, 32'd1);
    do_stop();
    chk("stop_wait_idle", {31'd0, running}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      int  leff;
      bit  ok;
      leff = (vecs[v].len > DEPTH) ? DEPTH : vecs[v].len;
      length = 5'(vecs[v].len); repeat_count = 8'(vecs[v].rep); loop = vecs[v].lp;
      clear_log();
      pulse_start();
      for (int w = 0; w < vecs[v].nwraps; w++) do_wrap();
      repeat (4) tick();
      chk($sformatf("v%0d_writes", v), wr_data.size(), vecs[v].exp_writes);
      if (wr_data.size() > 0)
        chk($sformatf("v%0d_last", v), wr_data[wr_data.size()-1], vecs[v].exp_last);
      chk($sformatf("v%0d_done", v), done_cnt, vecs[v].exp_done);
      chk($sformatf("v%0d_running", v), {31'd0, running}, {31'd0, vecs[v].exp_run});
      if (vecs[v].exp_step >= 0)
        chk($sformatf("v%0d_step", v), {28'd0, step_index}, vecs[v].exp_step);
      ok = 1'b1;
      for (int k = 0; k < wr_data.size(); k++)
        if (wr_data[k] !== 32'((k % leff + 1) * 10)) ok = 1'b0;
      chk($sformatf("v%0d_seq", v), {31'd0, ok}, 32'd1);
      do_stop();
      chk($sformatf("v%0d_idle", v), {31'd0, running}, 32'd0);
    end

    // Reset during a stalled write; table survives.
    length = 5'd4; repeat_count = 8'd1; loop = 1'b0;
    busy = 1'b1;
    pulse_start();
    chk("prerst_we", {31'd0, we}, 32'd1);
    rst = 1'b0;
    tick();
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_bus", {addr, 12'd0, bs}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_run_step_done", {26'd0, running, step_index, seq_done}, 32'd0);
    rst = 1'b1; busy = 1'b0;
    tick();
    pulse_start();
    chk("rst_replay_data", data, 32'd10);
    tick();
    do_stop();

    // Stall with a wrap arriving mid-stall.
    length = 5'd2; repeat_count = 8'd1; loop = 1'b1;
    clear_log();
    busy = 1'b1;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      period_wrap = (i == 2);
      tick();
      chk($sformatf("stall_%0d", i), {we, data[30:0]}, {1'b1, 31'd10});
    end
    period_wrap = 1'b0;
    busy = 1'b0;
    tick();
    chk("stall_done_we", {31'd0, we}, 32'd0);
    tick();
    chk("pend_wrap_we", {31'd0, we}, 32'd1);
    chk("pend_wrap_data", data, 32'd20);
    tick();
    do_stop();
    chk("stall_writes", wr_data.size(), 2);
    chk("stall_bus_fields", bad_bus, 0);

    // Stop latched during a stalled write.
    length = 5'd4; repeat_count = 8'd1; loop = 1'b0;
    clear_log();
    busy = 1'b1;
    pulse_start();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_stall_we", {30'd0, we, running}, 32'd3);
    tick();
    busy = 1'b0;
    tick();
    chk("stop_stall_end", {30'd0, we, running}, 32'd0);
    do_wrap();
    do_wrap();
    chk("stop_stall_writes", wr_data.size(), 1);

    // start and stop together in IDLE.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", {30'd0, we, running}, 32'd0);
    tick();
    chk("start_stop_idle2", {30'd0, we, running}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/pwm_sequencer.md
# pwm_sequencer

Bus-master sequencer that plays a table of duty values into one compare register of a PWM device, one entry per N PWM periods. It sits beside the PWM device on the peripheral bus and writes the compare register at period boundaries, so that duty updates are aligned to the counter wrap. Typical uses are LED fades, tone envelopes and motor ramps without CPU intervention. One-shot and looping playback are supported, with a completion interrupt.

## Interface
Parameters:
- DEPTH, 16, number of table entries (power of two, ≥2)
- WIDTH, 16, duty value width; matches the PWM compare width
- COMPARE_ADDRESS, 16'h0008, full peripheral-bus address of the target compare register

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-low
- table_we  input  1  write strobe for table entry
- table_addr  input  $clog2(DEPTH)  table entry index
- table_data  input  WIDTH  duty value to store
- start  input  1  pulse; begins playback from entry 0
- stop  input  1  pulse; ends playback
- loop  input  1  1 = wrap to entry 0 after last entry; 0 = one-shot
- length  input  $clog2(DEPTH)+1  entries to play; clamped to DEPTH
- repeat_count  input  8  PWM periods per entry; 0 treated as 1
- period_wrap  input  1  one-cycle pulse from the PWM counter at each wrap to 0
- peripheralBus_we  output  1  master write request
- peripheralBus_address  output  16  COMPARE_ADDRESS while writing, else 0
- peripheralBus_byteSelect  output  4  4'b1111 while writing, else 0
- peripheralBus_dataWrite  output  32  zero-extended duty value while writing, else 0
- peripheralBus_busy  input  1  slave stall
- running  output  1  high in any state except IDLE
- step_index  output  $clog2(DEPTH)  index of the entry most recently written
- seq_done  output  1  one-cycle pulse when one-shot playback ends

## Operation
- Table: DEPTH×WIDTH register array, written any time by table_we. Writing while running is allowed; the new value is used the next time that entry is fetched.
- Effective length is min(length, DEPTH). Effective repeat is max(repeat_count, 1). Both are sampled on start.
- FSM states:
  - IDLE
    - start with effective length ≠ 0 → index=0, period count=0 → WRITE.
    - start with effective length = 0 is ignored.
  - WRITE
    - we=1; address, byteSelect and dataWrite are driven from table[index].
    - The write completes in the first cycle with we=1 and busy=0; step_index updates to index in that cycle.
    - On completion → IDLE if a stop is pending, else → WAIT.
  - WAIT
    - Each period_wrap increments the period count.
    - When the count reaches effective repeat, the count clears and:
      - if index < len-1: index+1 → WRITE
      - else if loop: index=0 → WRITE
      - else: seq_done pulse → IDLE
- stop
  - In WAIT: → IDLE next cycle.
  - In WRITE: latched; the current write is never aborted and completes first.
  - In IDLE: no effect.
- start while running is ignored.
- A period_wrap arriving during WRITE is latched in a one-deep pending flag and processed on entry to WAIT. Further wraps while the flag is set are dropped.
- start and stop in the same cycle: stop wins; the block stays in or returns to IDLE.
- Reset (rst=0 at a clock edge), including mid-write:
  - state IDLE, all bus outputs 0, running=0, step_index=0, seq_done=0.
  - Pending flags and counters clear.
  - The table contents are not reset.

## Timing
- All outputs are registered.
- start at edge N → peripheralBus_we=1 from cycle N+1.
- A write completing at edge M, with no pending wrap → WAIT at M+1. we returns to 0 at M+1.
- period_wrap at edge K that advances the step → we=1 from K+1. Duty therefore lands 2 cycles after the wrap, with busy=0.
- seq_done is high for exactly the cycle after the final wrap. running falls in the same cycle.
- Back-to-back writes are impossible; at least one WAIT cycle separates them.

## Test plan
- length=4, repeat=1, loop=0, table={10,20,30,40}, busy=0, wrap every 8 cycles → four writes of 10, 20, 30, 40 to 16'h0008, one per wrap. seq_done pulses once after the 4th wrap; then running=0.
- repeat=3, length=2, loop=1 → each value is held for exactly 3 wraps. Sequence 10,20,10,20… continues until stop in WAIT, which gives IDLE the next cycle.
- busy held high 5 cycles during a write, with a period_wrap during the stall → we and data stable for the full stall. The wrap is processed immediately after completion; the next write is issued 2 cycles after the write completes.
- stop asserted during a stalled write → the write completes, then IDLE with no further writes. start and stop in the same cycle in IDLE → remains IDLE.
- length=0 start → ignored, running=0. length=20 with DEPTH=16 → entries 0..15 played.
- rst=0 mid-WRITE → next cycle all outputs 0 and state IDLE. A subsequent start replays from entry 0 using the retained table.
